// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus a memory-mapped I/O page holding a
// free-running cycle counter, a TX FIFO drained by a ready/valid sink, and a
// saturating dropped-push counter. Loads are combinational, stores commit on
// the rising edge.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   dmem_we           store strobe from the core
//   dmem_addr         byte address; bits [1:0] ignored
//   dmem_wdata        store data
//   dmem_rdata        load data, combinational from address and current state
//   tx_valid/tx_data  FIFO head towards the sink (tx_data is 0 when empty)
//   tx_ready          sink accepts the head on this edge
module dmem_mmio #(
    parameter int unsigned RAM_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;
    localparam logic [1:0] OFF_DROPS  = 2'd3;

    logic [31:0]       mem [RAM_WORDS];
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       cycle_cnt;
    logic [31:0]       drops_cnt;

    logic              is_io;
    logic [1:0]        io_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic [31:0]       status_word;

    // Address decode; IO_BASE is 64 KiB aligned, so the in-page offset's
    // register select equals addr[3:2] and offsets alias mod 0x10.
    assign is_io   = (dmem_addr >= IO_BASE);
    assign io_sel  = dmem_addr[3:2];
    assign ram_idx = dmem_addr[RAM_AW+1:2];

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign pop      = !fifo_empty && tx_ready;
    assign push_req = dmem_we && is_io && (io_sel == OFF_TXDATA);
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];

    assign status_word = (32'(count) << 4) | {30'h0, fifo_empty, fifo_full};

    // RAM store port; contents are not reset.
    always_ff @(posedge clk) begin
        if (dmem_we && !is_io) begin
            mem[ram_idx] <= dmem_wdata;
        end
    end

    // FIFO storage; only the pointers and count carry reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= dmem_wdata;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Cycle counter: a store loads it in place of the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (dmem_we && is_io && (io_sel == OFF_CYCLE)) begin
            cycle_cnt <= dmem_wdata;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Dropped-push counter: any store clears, otherwise saturating increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drops_cnt <= '0;
        end else if (dmem_we && is_io && (io_sel == OFF_DROPS)) begin
            drops_cnt <= '0;
        end else if (drop && (drops_cnt != 32'hFFFF_FFFF)) begin
            drops_cnt <= drops_cnt + 32'd1;
        end
    end

    // Load mux.
    always_comb begin
        dmem_rdata = 32'h0;
        if (is_io) begin
            case (io_sel)
                OFF_TXDATA: dmem_rdata = 32'h0;
                OFF_STATUS: dmem_rdata = status_word;
                OFF_CYCLE:  dmem_rdata = cycle_cnt;
                OFF_DROPS:  dmem_rdata = drops_cnt;
                default:    dmem_rdata = 32'h0;
            endcase
        end else begin
            dmem_rdata = mem[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed testbench for dmem_mmio (RAM_WORDS=256, FIFO_DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_dmem_mmio;

    localparam logic [31:0] IO     = 32'hFFFF_0000;
    localparam logic [31:0] A_TX   = IO + 32'h0;
    localparam logic [31:0] A_STAT = IO + 32'h4;
    localparam logic [31:0] A_CYC  = IO + 32'h8;
    localparam logic [31:0] A_DROP = IO + 32'hC;

    logic        clk;
    logic        rst;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;

    int checks   = 0;
    int failures = 0;

    dmem_mmio #(
        .RAM_WORDS (256),
        .FIFO_DEPTH(4),
        .IO_BASE   (32'hFFFF_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Store over one edge, leaving inputs idle 1 unit after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dmem_we    = 1'b1;
        dmem_addr  = a;
        dmem_wdata = d;
        @(posedge clk);
        #1;
        dmem_we    = 1'b0;
    endtask

    // Present a load address and let the combinational path settle.
    task automatic rd(input logic [31:0] a);
        dmem_addr = a;
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got %0b exp 0", tx_valid); end
        checks++; if (tx_data !== 32'h0) begin failures++; $display("FAIL reset_tx_data got %h exp 0", tx_data); end
        rd(A_STAT);
        checks++; if (dmem_rdata !== 32'h2) begin failures++; $display("FAIL reset_status got %h exp 00000002", dmem_rdata); end
        @(posedge clk); #1;
        rd(A_CYC);
        checks++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL reset_cycle_held got %h exp 0", dmem_rdata); end
        rd(A_DROP);
        checks++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL reset_drops got %h exp 0", dmem_rdata); end
        rst = 1'b0;
        @(posedge clk); #1;
        rd(A_CYC);
        checks++; if (dmem_rdata !== 32'h1) begin failures++; $display("FAIL cycle_first_edge got %h exp 1", dmem_rdata); end
    endtask

    task automatic test_ram;
        wr(32'h40, 32'hDEAD_BEEF);
        wr(32'h44, 32'h1234_5678);
        rd(32'h40);
        checks++; if (dmem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_load got %h exp deadbeef", dmem_rdata); end
        rd(32'h40 + 32'd1024);
        checks++; if (dmem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_alias got %h exp deadbeef", dmem_rdata); end
        rd(32'h43);
        checks++; if (dmem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_low_bits got %h exp deadbeef", dmem_rdata); end
        rd(32'h44);
        checks++; if (dmem_rdata !== 32'h1234_5678) begin failures++; $display("FAIL ram_next_word got %h exp 12345678", dmem_rdata); end
        // Store aliasing onto 0x40 overwrites the same word.
        wr(32'h40 + 32'd2048, 32'hCAFE_F00D);
        rd(32'h40);
        checks++; if (dmem_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_alias_store got %h exp cafef00d", dmem_rdata); end
    endtask

    task automatic test_fifo_fill;
        tx_ready = 1'b0;
        wr(A_TX, 32'd1);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 32'd1) begin failures++; $display("FAIL first_push_head got v=%0b d=%h exp v=1 d=1", tx_valid, tx_data); end
        for (int i = 2; i <= 5; i++) wr(A_TX, 32'(i));
        rd(A_STAT);
        checks++; if (dmem_rdata !== 32'h41) begin failures++; $display("FAIL full_status got %h exp 00000041", dmem_rdata); end
        rd(A_DROP);
        checks++; if (dmem_rdata !== 32'h1) begin failures++; $display("FAIL full_drops got %h exp 1", dmem_rdata); end
        checks++; if (tx_data !== 32'd1) begin failures++; $display("FAIL head_stable got %h exp 1", tx_data); end
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== 32'(i)) begin failures++; $display("FAIL drain_%0d got v=%0b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 32'(i)); end
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin failures++; $display("FAIL drained_empty got v=%0b d=%h exp v=0 d=0", tx_valid, tx_data); end
        rd(A_STAT);
        checks++; if (dmem_rdata !== 32'h2) begin failures++; $display("FAIL drained_status got %h exp 00000002", dmem_rdata); end
    endtask

    task automatic test_regs;
        wr(A_DROP, 32'h5555_AAAA);
        rd(A_DROP);
        checks++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL drops_clear got %h exp 0", dmem_rdata); end
        wr(A_TX, 32'hABCD_0001);
        rd(A_TX);
        checks++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL txdata_read got %h exp 0", dmem_rdata); end
        wr(A_STAT, 32'h0000_FFFF);
        rd(A_STAT);
        checks++; if (dmem_rdata !== 32'h10) begin failures++; $display("FAIL status_write_ignored got %h exp 00000010", dmem_rdata); end
        rd(IO + 32'h14);
        checks++; if (dmem_rdata !== 32'h10) begin failures++; $display("FAIL status_alias got %h exp 00000010", dmem_rdata); end
        checks++; if (tx_data !== 32'hABCD_0001) begin failures++; $display("FAIL single_head got %h exp abcd0001", tx_data); end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL single_pop got v=%0b exp 0", tx_valid); end
    endtask

    task automatic test_back_to_back;
        tx_ready = 1'b0;
        for (int i = 5; i <= 8; i++) wr(A_TX, 32'(i));
        rd(A_TX);
        checks++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL txdata_read_full got %h exp 0", dmem_rdata); end
        tx_ready = 1'b1;
        wr(A_TX, 32'd9);
        tx_ready = 1'b0;
        rd(A_STAT);
        checks++; if (dmem_rdata !== 32'h41) begin failures++; $display("FAIL pushpop_status got %h exp 00000041", dmem_rdata); end
        rd(A_DROP);
        checks++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL pushpop_drops got %h exp 0", dmem_rdata); end
        tx_ready = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== 32'(i)) begin failures++; $display("FAIL pushpop_drain_%0d got v=%0b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 32'(i)); end
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL pushpop_empty got v=%0b exp 0", tx_valid); end
    endtask

    task automatic test_cycle;
        wr(A_CYC, 32'hFFFF_FFFE);
        rd(A_CYC);
        checks++; if (dmem_rdata !== 32'hFFFF_FFFE) begin failures++; $display("FAIL cycle_load got %h exp fffffffe", dmem_rdata); end
        @(posedge clk); #1;
        checks++; if (dmem_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cycle_max got %h exp ffffffff", dmem_rdata); end
        @(posedge clk); #1;
        checks++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL cycle_wrap got %h exp 0", dmem_rdata); end
    endtask

    task automatic test_async_reset;
        tx_ready = 1'b0;
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        rd(A_STAT);
        checks++; if (dmem_rdata !== 32'h20) begin failures++; $display("FAIL two_entry_status got %h exp 00000020", dmem_rdata); end
        rst = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin failures++; $display("FAIL async_rst_tx got v=%0b d=%h exp v=0 d=0", tx_valid, tx_data); end
        rd(A_STAT);
        checks++; if (dmem_rdata !== 32'h2) begin failures++; $display("FAIL async_rst_status got %h exp 00000002", dmem_rdata); end
        rd(A_CYC);
        checks++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL async_rst_cycle got %h exp 0", dmem_rdata); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL post_rst_empty got v=%0b exp 0", tx_valid); end
        rd(A_CYC);
        checks++; if (dmem_rdata !== 32'h1) begin failures++; $display("FAIL post_rst_cycle got %h exp 1", dmem_rdata); end
    endtask

    initial begin
        rst        = 1'b1;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        tx_ready   = 1'b0;
        test_reset();
        test_ram();
        test_fifo_fill();
        test_regs();
        test_back_to_back();
        test_cycle();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory stage downstream of the core's dmem port: consumes `dmem_we`/`dmem_addr`/`dmem_wdata` and returns `dmem_rdata`. It holds word-addressed data RAM plus a memory-mapped I/O page containing a free-running cycle counter, a transmit FIFO drained by an external ready/valid sink, and a dropped-write counter. Reads are combinational so a single-cycle core completes loads in the same cycle. Writes commit on the rising clock edge.

## Interface
- `RAM_WORDS`, 256: data RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2..16.
- `IO_BASE`, 32'hFFFF_0000: first byte address of the I/O page (64 KiB page, 16-bit aligned).

- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dmem_we`  in  1  write strobe from core.
- `dmem_addr`  in  32  byte address (ALU result).
- `dmem_wdata`  in  32  store data.
- `dmem_rdata`  out  32  load data, combinational.
- `tx_valid`  out  1  FIFO head valid.
- `tx_data`  out  32  FIFO head word.
- `tx_ready`  in  1  sink accepts head this cycle.

## Operation
- Decode: `dmem_addr >= IO_BASE` selects I/O; otherwise RAM. `addr[1:0]` ignored everywhere. RAM index = `addr[log2(RAM_WORDS)+1:2]`; higher bits alias (wrap).
- RAM: write `mem[idx] <= dmem_wdata` on edge when `dmem_we`. Not reset; contents undefined after reset. Read combinational.
- I/O offsets (`addr - IO_BASE`, bits [3:2]; offsets ≥ 0x10 alias mod 0x10):
  - 0x0 TXDATA: write pushes `dmem_wdata`; read returns 0.
  - 0x4 STATUS (read-only, writes ignored): bit0 full, bit1 empty, bits[8:4] occupancy count, rest 0.
  - 0x8 CYCLE: read current count; write loads `dmem_wdata`.
  - 0xC DROPS: read count of pushes rejected while full; saturates at 32'hFFFF_FFFF; any write clears to 0.
- FIFO: circular buffer, rd/wr pointers plus count.
  - `tx_valid = !empty`; `tx_data = entry[rd_ptr]`, driven 0 when empty.
  - Pop on edge when `tx_valid && tx_ready`.
  - Push on edge when TXDATA written and (not full, or pop on same edge).
  - Push while full with no pop is dropped and DROPS increments.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo `FIFO_DEPTH`.
- CYCLE increments by 1 every edge, wrapping 2^32−1 → 0. A write on an edge loads the written value; that edge does not increment.
- STATUS/CYCLE/DROPS reads reflect register state before the edge (combinational from current registers).

## Timing
- Reset (async, immediate): FIFO empty (`tx_valid`=0, `tx_data`=0), pointers 0, CYCLE=0, DROPS=0. `dmem_rdata` stays combinational from address; STATUS reads 0x2 during reset.
- Load latency 0 cycles (same-cycle combinational). Store and push take effect at the next edge and are visible to reads in the following cycle.
- Pushed word appears on `tx_data`/`tx_valid` the cycle after the push edge (when the FIFO was empty).
- `tx_valid` never drops without a pop or reset. `tx_data` is stable while `tx_valid && !tx_ready`.
- Reset mid-transfer discards all FIFO contents. A sink must not count the handshake on an edge where `rst` is high.

## Test plan
- Reset, then RAM store 0xDEADBEEF to 0x40 and load 0x40 → rdata 0xDEADBEEF. Load 0x40+4*RAM_WORDS → same (alias). Load 0x43 → same.
- Hold `tx_ready`=0 and push 1..5 with depth 4 → STATUS 0x41 (full, count 4), DROPS=1. Raise `tx_ready` → tx_data sequence 1,2,3,4, then `tx_valid`=0 and STATUS 0x2.
- FIFO full with `tx_ready`=1 and push 9 on the same edge → accepted, DROPS unchanged, count stays 4, 9 emerges last.
- Write CYCLE=0xFFFF_FFFE, read on the next two cycles → 0xFFFF_FFFE then 0xFFFF_FFFF, then 0x0 on the third.
- Write DROPS → reads 0. Read TXDATA → 0. Write STATUS 0xFFFF → STATUS unchanged.
- Fill the FIFO with 2 entries, assert `rst` asynchronously between edges → `tx_valid` falls immediately, STATUS 0x2, CYCLE 0.
